// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer.
// Bit order is chosen by BIT_SERIALIZER_LSB_FIRST_EN (MSB-first by default).
package bit_serializer_pkg;

  localparam int unsigned DEF_WIDTH    = 8;
  localparam logic        DEF_IDLE_BIT = 1'b0;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_serializer_counter.sv
// Modulo-WIDTH bit counter with terminal-count flag.
// Parks at 0 whenever it is not enabled or is cleared.
module bit_counter
  import bit_serializer_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  assign tc = (cnt == LAST);

  // Terminal count returns to 0, so the counter never wraps past LAST.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || !en || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter, one bit per clk, gapless back-to-back words.
// Define BIT_SERIALIZER_LSB_FIRST_EN for LSB-first output order.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter logic        IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             load;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] load_rest;
  logic [WIDTH-1:0] shift_rest;

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
  assign first_bit  = data_in[0];
  assign load_rest  = data_in >> 1;
  assign next_bit   = sreg[0];
  assign shift_rest = sreg >> 1;
`else
  assign first_bit  = data_in[WIDTH-1];
  assign load_rest  = data_in << 1;
  assign next_bit   = sreg[WIDTH-1];
  assign shift_rest = sreg << 1;
`endif

  assign load_ready = (state == IDLE) || tc;
  assign load       = load_valid && load_ready;
  assign done       = (state == SHIFT) && tc;

  bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (state == SHIFT),
    .cnt   (cnt),
    .tc    (tc)
  );

  // x holds the bit on the line; sreg holds the bits still to come.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sreg    <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
    end else if (load) begin
      state   <= SHIFT;
      sreg    <= load_rest;
      x       <= first_bit;
      x_valid <= 1'b1;
      busy    <= 1'b1;
    end else if (state == SHIFT && !tc) begin
      sreg    <= shift_rest;
      x       <= next_bit;
    end else begin
      state   <= IDLE;
      sreg    <= '0;
      x       <= IDLE_BIT;
      x_valid <= 1'b0;
      busy    <= 1'b0;
    end
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, default 8, word width in bits (legal range 2..16).
REQ-002 Parameter: IDLE_BIT, default 1'b0, value driven on x while no word is being shifted.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: load_valid  input  1  producer offers data_in this cycle.
REQ-006 Port: data_in  input  WIDTH  parallel word to serialize.
REQ-007 Port: load_ready  output  1  serializer can accept a word this cycle.
REQ-008 Port: x  output  1  serial bit stream feeding the downstream sequence detector, one bit per clk.
REQ-009 Port: x_valid  output  1  x carries a data bit this cycle.
REQ-010 Port: busy  output  1  a word is being shifted.
REQ-011 Port: done  output  1  one-cycle pulse on the cycle the last bit of a word is on x.

Function
REQ-012 The block SHALL implement an FSM with states IDLE and SHIFT only.
REQ-013 A load SHALL occur on a posedge where load_valid and load_ready are both 1; data_in SHALL be captured into a WIDTH-bit shift register.
REQ-014 load_ready SHALL be 1 in IDLE, and 1 in SHIFT only when the bit counter equals WIDTH-1 (last bit); otherwise 0.
REQ-015 IDLE -> SHIFT on a load; SHIFT -> IDLE when the last bit completes with no load; SHIFT stays SHIFT with counter reset to 0 on a load during the last bit (gapless back-to-back words).
REQ-016 First bit of a loaded word SHALL appear on x in the cycle after the load edge (latency 1); bits SHALL be MSB-first by default, one per cycle, WIDTH cycles per word.
REQ-017 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, count 0..WIDTH-1, and SHALL never wrap past WIDTH-1.
REQ-018 In SHIFT, x_valid=1 and busy=1; in IDLE, x_valid=0, busy=0, x=IDLE_BIT.
REQ-019 done SHALL be 1 exactly when state is SHIFT and counter equals WIDTH-1, independent of a simultaneous load.
REQ-020 x, x_valid, busy SHALL be driven from registers (no combinational path from load_valid or data_in); load_ready and done MAY be decoded from state/counter only.
REQ-021 load_valid while load_ready=0 SHALL be ignored and SHALL NOT alter the word in progress; data_in changes mid-word SHALL have no effect.

Reset
REQ-022 While reset=0, state SHALL be IDLE, counter 0, shift register 0, x=IDLE_BIT, x_valid=0, busy=0, done=0, load_ready=1 (after deassertion).
REQ-023 Reset asserted mid-word SHALL abort the word immediately (asynchronously); no remaining bits SHALL be emitted after release.
REQ-024 The first load SHALL be accepted on the first posedge after reset deassertion with load_valid=1.

Configuration
REQ-025 Macro BIT_SERIALIZER_LSB_FIRST_EN: when defined, bits SHALL be emitted LSB-first; when undefined, MSB-first; all timing identical in both builds.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH/IDLE_BIT constants.
REQ-027 A single sub-module bit_counter (modulo-WIDTH counter with terminal-count output) is natural; the FSM and shift register stay in bit_serializer.

Verification
REQ-028 Reset release, load 8'b1001_0110 -> x = 1,0,0,1,0,1,1,0 on cycles 1..8 after load, x_valid=1 for 8 cycles, done on cycle 8, then x=0, load_ready=1.
REQ-029 Two words 8'hA5, 8'h3C offered back-to-back with load_valid held -> 16 consecutive valid bits with no gap, done pulses on cycles 8 and 16.
REQ-030 load_valid pulsed with 8'hFF on cycle 3 of word 8'h00 -> ignored, x stays 0 for all 8 bits, load_ready=0 on that cycle.
REQ-031 reset driven low on cycle 4 of word 8'hF0 -> x=IDLE_BIT, x_valid=0, busy=0 at once; after release no residual bits.
REQ-032 Build with BIT_SERIALIZER_LSB_FIRST_EN, load 8'b0000_0011 -> x = 1,1,0,0,0,0,0,0.
REQ-033 End-to-end: serializer x fed to the sequence detector with words encoding the detector's target pattern -> detector y asserts on the expected cycles; no y during idle stretches.
